// File: rtl/cpu_run_controller.sv
// Execution sequencer for the Aeolus core: gates cpuEnable for free-run, single-step,
// user halt, PC breakpoint and halt-opcode stops, always on instruction boundaries.
module cpu_run_controller #(
    parameter int          PC_W         = 8,
    parameter int          CNT_W        = 16,
    parameter logic [3:0]  HALT_OPCODE  = 4'b1111,
    parameter bit          RUN_ON_RESET = 1'b0
) (
    input  logic             boardCLK,
    input  logic             reset,
    input  logic             runReq,
    input  logic             haltReq,
    input  logic             stepReq,
    input  logic             clrCount,
    input  logic             bpEnable,
    input  logic [PC_W-1:0]  bpAddr,
    input  logic [PC_W-1:0]  pcIn,
    input  logic [3:0]       opcodeIn,
    input  logic             instrDone,
    output logic             cpuEnable,
    output logic [1:0]       cpuState,
    output logic             halted,
    output logic [2:0]       haltCause,
    output logic [CNT_W-1:0] retiredCount
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_USER  = 3'd1;
    localparam logic [2:0] CAUSE_STEP  = 3'd2;
    localparam logic [2:0] CAUSE_BP    = 3'd3;
    localparam logic [2:0] CAUSE_HALTOP = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       cause_q, cause_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic retire;
    logic opStop;
    logic bpHit;

    assign retire = instrDone & (state_q != ST_HALT);
    assign opStop = (opcodeIn == HALT_OPCODE);
    assign bpHit  = bpEnable & (pcIn == bpAddr);

    always_ff @(posedge boardCLK) begin
        if (reset) begin
            state_q <= RUN_ON_RESET ? ST_RUN : ST_HALT;
            cause_q <= CAUSE_RESET;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Halt-opcode outranks breakpoint, which outranks the state-specific reason.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            ST_HALT: begin
                if (runReq) begin
                    state_d = ST_RUN;
                end else if (stepReq) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (retire) begin
                    if (opStop) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_HALTOP;
                    end else if (bpHit) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_BP;
                    end else if (haltReq) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_USER;
                    end
                end else if (haltReq) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (retire) begin
                    state_d = ST_HALT;
                    cause_d = opStop ? CAUSE_HALTOP : (bpHit ? CAUSE_BP : CAUSE_STEP);
                end
            end
            ST_DRAIN: begin
                if (retire) begin
                    state_d = ST_HALT;
                    cause_d = opStop ? CAUSE_HALTOP : (bpHit ? CAUSE_BP : CAUSE_USER);
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Clear beats a same-cycle retire; the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clrCount) begin
            count_d = '0;
        end else if (retire && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign cpuEnable    = (state_q != ST_HALT);
    assign cpuState     = state_q;
    assign halted       = (state_q == ST_HALT);
    assign haltCause    = cause_q;
    assign retiredCount = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: a table of per-cycle vectors plus
// hand-written saturation/reset sequences, compared through an expected-result queue.
module tb_cpu_run_controller;

    localparam int PC_W  = 8;
    localparam int CNT_W = 4;

    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] S = 2'b10;
    localparam logic [1:0] D = 2'b11;

    logic             boardCLK = 1'b0;
    logic             reset, runReq, haltReq, stepReq, clrCount, bpEnable, instrDone;
    logic [PC_W-1:0]  bpAddr, pcIn;
    logic [3:0]       opcodeIn;
    logic             cpuEnable, halted;
    logic [1:0]       cpuState;
    logic [2:0]       haltCause;
    logic [CNT_W-1:0] retiredCount;

    int checks = 0;
    int errors = 0;

    // ctl bit order: {reset, runReq, haltReq, stepReq, clrCount, bpEnable, instrDone}
    typedef struct packed {
        logic [6:0]       ctl;
        logic [PC_W-1:0]  bpa;
        logic [PC_W-1:0]  pc;
        logic [3:0]       op;
        logic [1:0]       expState;
        logic [2:0]       expCause;
        logic [CNT_W-1:0] expCount;
    } vec_t;

    typedef struct packed {
        logic [1:0]       st;
        logic [2:0]       cause;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];

    always #5 boardCLK = ~boardCLK;

    cpu_run_controller #(
        .PC_W(PC_W),
        .CNT_W(CNT_W),
        .HALT_OPCODE(4'b1111),
        .RUN_ON_RESET(1'b0)
    ) dut (
        .boardCLK(boardCLK),
        .reset(reset),
        .runReq(runReq),
        .haltReq(haltReq),
        .stepReq(stepReq),
        .clrCount(clrCount),
        .bpEnable(bpEnable),
        .bpAddr(bpAddr),
        .pcIn(pcIn),
        .opcodeIn(opcodeIn),
        .instrDone(instrDone),
        .cpuEnable(cpuEnable),
        .cpuState(cpuState),
        .halted(halted),
        .haltCause(haltCause),
        .retiredCount(retiredCount)
    );

    function automatic vec_t mkVec(input logic [6:0] ctl, input logic [7:0] bpa, input logic [7:0] pc,
                                   input logic [3:0] op, input logic [1:0] st, input logic [2:0] c,
                                   input logic [3:0] n);
        vec_t v;
        v.ctl      = ctl;
        v.bpa      = bpa;
        v.pc       = pc;
        v.op       = op;
        v.expState = st;
        v.expCause = c;
        v.expCount = n;
        return v;
    endfunction

    task automatic addVec(input logic [6:0] ctl, input logic [7:0] bpa, input logic [7:0] pc,
                          input logic [3:0] op, input logic [1:0] st, input logic [2:0] c,
                          input logic [3:0] n);
        vecs.push_back(mkVec(ctl, bpa, pc, op, st, c, n));
    endtask

    task automatic checkField(input string tag, input string field, input logic [15:0] act,
                              input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s queue: got empty expected entry", tag);
        end else begin
            e = expQ.pop_front();
            checkField(tag, "cpuState", 16'(cpuState), 16'(e.st));
            checkField(tag, "cpuEnable", 16'(cpuEnable), 16'(e.st != H));
            checkField(tag, "halted", 16'(halted), 16'(e.st == H));
            checkField(tag, "haltCause", 16'(haltCause), 16'(e.cause));
            checkField(tag, "retiredCount", 16'(retiredCount), 16'(e.cnt));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        {reset, runReq, haltReq, stepReq, clrCount, bpEnable, instrDone} = v.ctl;
        bpAddr   = v.bpa;
        pcIn     = v.pc;
        opcodeIn = v.op;
        e.st     = v.expState;
        e.cause  = v.expCause;
        e.cnt    = v.expCount;
        expQ.push_back(e);
        @(posedge boardCLK);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        {reset, runReq, haltReq, stepReq, clrCount, bpEnable, instrDone} = '0;
        bpAddr   = '0;
        pcIn     = '0;
        opcodeIn = '0;

        // Reset, then instrDone while halted is ignored
        addVec(7'b1000000, 8'h00, 8'h00, 4'h0, H, 3'd0, 4'd0);
        addVec(7'b1000000, 8'h00, 8'h00, 4'h0, H, 3'd0, 4'd0);
        addVec(7'b0000001, 8'h00, 8'h01, 4'h0, H, 3'd0, 4'd0);
        addVec(7'b0000001, 8'h00, 8'h02, 4'h0, H, 3'd0, 4'd0);
        // Free run, haltReq mid-instruction drains to the next retire
        addVec(7'b0100000, 8'h00, 8'h00, 4'h0, R, 3'd0, 4'd0);
        addVec(7'b0000001, 8'h00, 8'h01, 4'h0, R, 3'd0, 4'd1);
        addVec(7'b0000001, 8'h00, 8'h02, 4'h0, R, 3'd0, 4'd2);
        addVec(7'b0000001, 8'h00, 8'h03, 4'h0, R, 3'd0, 4'd3);
        addVec(7'b0000001, 8'h00, 8'h04, 4'h0, R, 3'd0, 4'd4);
        addVec(7'b0000001, 8'h00, 8'h05, 4'h0, R, 3'd0, 4'd5);
        addVec(7'b0000000, 8'h00, 8'h05, 4'h0, R, 3'd0, 4'd5);
        addVec(7'b0010000, 8'h00, 8'h05, 4'h0, D, 3'd0, 4'd5);
        addVec(7'b0000000, 8'h00, 8'h05, 4'h0, D, 3'd0, 4'd5);
        addVec(7'b0100000, 8'h00, 8'h05, 4'h0, D, 3'd0, 4'd5);
        addVec(7'b0000001, 8'h00, 8'h06, 4'h0, H, 3'd1, 4'd6);
        addVec(7'b0000001, 8'h00, 8'h07, 4'h0, H, 3'd1, 4'd6);
        // Single step x3, haltReq ignored while stepping
        addVec(7'b1000000, 8'h00, 8'h00, 4'h0, H, 3'd0, 4'd0);
        addVec(7'b0001000, 8'h00, 8'h00, 4'h0, S, 3'd0, 4'd0);
        addVec(7'b0000000, 8'h00, 8'h00, 4'h0, S, 3'd0, 4'd0);
        addVec(7'b0000001, 8'h00, 8'h01, 4'h0, H, 3'd2, 4'd1);
        addVec(7'b0000000, 8'h00, 8'h01, 4'h0, H, 3'd2, 4'd1);
        addVec(7'b0001000, 8'h00, 8'h01, 4'h0, S, 3'd2, 4'd1);
        addVec(7'b0000001, 8'h00, 8'h02, 4'h0, H, 3'd2, 4'd2);
        addVec(7'b0001000, 8'h00, 8'h02, 4'h0, S, 3'd2, 4'd2);
        addVec(7'b0010000, 8'h00, 8'h02, 4'h0, S, 3'd2, 4'd2);
        addVec(7'b0000001, 8'h00, 8'h03, 4'h0, H, 3'd2, 4'd3);
        // runReq beats stepReq; cause holds until the next halt
        addVec(7'b0101000, 8'h00, 8'h03, 4'h0, R, 3'd2, 4'd3);
        addVec(7'b0010000, 8'h00, 8'h03, 4'h0, D, 3'd2, 4'd3);
        addVec(7'b0000001, 8'h00, 8'h04, 4'h0, H, 3'd1, 4'd4);
        // Breakpoint at 05, resume past it, loop back hits again
        addVec(7'b1000000, 8'h05, 8'h00, 4'h0, H, 3'd0, 4'd0);
        addVec(7'b0100010, 8'h05, 8'h00, 4'h0, R, 3'd0, 4'd0);
        addVec(7'b0000011, 8'h05, 8'h03, 4'h0, R, 3'd0, 4'd1);
        addVec(7'b0000011, 8'h05, 8'h04, 4'h0, R, 3'd0, 4'd2);
        addVec(7'b0000011, 8'h05, 8'h05, 4'h0, H, 3'd3, 4'd3);
        addVec(7'b0100010, 8'h05, 8'h05, 4'h0, R, 3'd3, 4'd3);
        addVec(7'b0000011, 8'h05, 8'h06, 4'h0, R, 3'd3, 4'd4);
        addVec(7'b0000011, 8'h05, 8'h07, 4'h0, R, 3'd3, 4'd5);
        addVec(7'b0000011, 8'h05, 8'h05, 4'h0, H, 3'd3, 4'd6);
        addVec(7'b0100000, 8'h05, 8'h05, 4'h0, R, 3'd3, 4'd6);
        addVec(7'b0000001, 8'h05, 8'h05, 4'h0, R, 3'd3, 4'd7);
        addVec(7'b0010001, 8'h05, 8'h09, 4'h0, H, 3'd1, 4'd8);
        // Stop-cause priority across RUN, STEP and DRAIN
        addVec(7'b1000000, 8'h05, 8'h00, 4'h0, H, 3'd0, 4'd0);
        addVec(7'b0100010, 8'h05, 8'h00, 4'h0, R, 3'd0, 4'd0);
        addVec(7'b0010011, 8'h05, 8'h05, 4'hF, H, 3'd4, 4'd1);
        addVec(7'b0001010, 8'h05, 8'h05, 4'h0, S, 3'd4, 4'd1);
        addVec(7'b0000011, 8'h05, 8'h05, 4'h0, H, 3'd3, 4'd2);
        addVec(7'b0100000, 8'h05, 8'h00, 4'h0, R, 3'd3, 4'd2);
        addVec(7'b0010000, 8'h05, 8'h00, 4'h0, D, 3'd3, 4'd2);
        addVec(7'b0000001, 8'h05, 8'h00, 4'hF, H, 3'd4, 4'd3);
        addVec(7'b0100010, 8'h05, 8'h00, 4'h0, R, 3'd4, 4'd3);
        addVec(7'b0010011, 8'h05, 8'h05, 4'h0, H, 3'd3, 4'd4);
        addVec(7'b0000100, 8'h05, 8'h00, 4'h0, H, 3'd3, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Saturation at 15, clear beating a retire, reset mid-RUN
        applyStimulus(mkVec(7'b1000000, 8'h00, 8'h00, 4'h0, H, 3'd0, 4'd0), "satReset");
        applyStimulus(mkVec(7'b0100000, 8'h00, 8'h00, 4'h0, R, 3'd0, 4'd0), "satRun");
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(mkVec(7'b0000001, 8'h00, 8'(i), 4'h0, R, 3'd0, 4'((i > 15) ? 15 : i)),
                          $sformatf("sat%0d", i));
        end
        applyStimulus(mkVec(7'b0000101, 8'h00, 8'h20, 4'h0, R, 3'd0, 4'd0), "clrWins");
        applyStimulus(mkVec(7'b0000001, 8'h00, 8'h21, 4'h0, R, 3'd0, 4'd1), "afterClr");
        applyStimulus(mkVec(7'b1000001, 8'h00, 8'h22, 4'h0, H, 3'd0, 4'd0), "resetMidRun");
        applyStimulus(mkVec(7'b0000001, 8'h00, 8'h23, 4'h0, H, 3'd0, 4'd0), "postReset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
